// File: rtl/one_clk_div.sv
// rtl/one_clk_div.sv - power-of-two clock divider (/2, /4, /8, /16) from one 4-bit counter
module one_clk_div (
  input  logic clk_in,
  input  logic rst,
  output logic clk_div_2,
  output logic clk_div_4,
  output logic clk_div_8,
  output logic clk_div_16
);

  // Power-up value keeps outputs low before the first reset; reset still defines phase.
  logic [3:0] cnt = 4'h0;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt <= 4'h0;
    end else begin
      cnt <= cnt + 4'd1;
    end
  end

  // Outputs come straight from register bits so they cannot glitch.
  assign clk_div_2  = cnt[0];
  assign clk_div_4  = cnt[1];
  assign clk_div_8  = cnt[2];
  assign clk_div_16 = cnt[3];

endmodule

// File: tb/tb_one_clk_div.sv
// tb/tb_one_clk_div.sv - scoreboard bench for one_clk_div with random reset and glitch stimulus
module tb_one_clk_div;

  logic clk_in = 1'b0;
  logic rst = 1'b0;
  logic clk_div_2, clk_div_4, clk_div_8, clk_div_16;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];
  int  edges_since_rst = 0;
  time last_rst_edge = 0;
  bit  done = 1'b0;

  one_clk_div dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .clk_div_2  (clk_div_2),
    .clk_div_4  (clk_div_4),
    .clk_div_8  (clk_div_8),
    .clk_div_16 (clk_div_16)
  );

  always #5 clk_in = ~clk_in;

  // Drive one clock edge worth of stimulus; called while clk_in is low.
  task automatic drive(input bit r, input bit glitch);
    rst = r;
    if (r) begin
      edges_since_rst = 0;
      last_rst_edge = $time + 5;
    end else begin
      edges_since_rst = edges_since_rst + 1;
    end
    exp_q.push_back(4'(edges_since_rst % 16));
    if (glitch && !r) begin
      #1 rst = 1'b1;
      #2 rst = 1'b0;
    end
    @(negedge clk_in);
  endtask

  // Monitor: pops expected values and measures periods and high times.
  initial begin : monitor
    logic [3:0] act;
    logic [3:0] prev;
    logic [3:0] exp_v;
    time rise_t[4];
    bit  have_rise[4];
    time t;
    for (int i = 0; i < 4; i++) begin
      rise_t[i] = 0;
      have_rise[i] = 1'b0;
    end
    #1;
    act = {clk_div_16, clk_div_8, clk_div_4, clk_div_2};
    checks++;
    if (act !== 4'b0000) begin
      errors++;
      $display("FAIL power_up actual=%b required=0000", act);
    end
    prev = act;
    forever begin
      @(posedge clk_in);
      t = $time;
      #1;
      act = {clk_div_16, clk_div_8, clk_div_4, clk_div_2};
      if (exp_q.size() == 0) begin
        if (!done) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow at %0t actual=%b required=expected-entry", t, act);
        end
      end else begin
        exp_v = exp_q.pop_front();
        checks++;
        if (act !== exp_v) begin
          errors++;
          $display("FAIL seq at %0t actual=%b required=%b", t, act, exp_v);
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (!prev[i] && act[i]) begin
          if (have_rise[i] && rise_t[i] > last_rst_edge) begin
            checks++;
            if (t - rise_t[i] != time'(20 << i)) begin
              errors++;
              $display("FAIL period_div%0d actual=%0t required=%0d", 2 << i, t - rise_t[i], 20 << i);
            end
          end
          rise_t[i] = t;
          have_rise[i] = 1'b1;
        end else if (prev[i] && !act[i]) begin
          if (have_rise[i] && rise_t[i] > last_rst_edge) begin
            checks++;
            if (t - rise_t[i] != time'(10 << i)) begin
              errors++;
              $display("FAIL high_div%0d actual=%0t required=%0d", 2 << i, t - rise_t[i], 10 << i);
            end
          end
        end
      end
      prev = act;
    end
  end

  initial begin : stimulus
    // Reset held across edges 5..115 ns, released for 125 ns onward.
    for (int i = 0; i < 12; i++) drive(1'b1, 1'b0);
    // One full wrap (0001 .. 1111, 0000), then on to 1011.
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b0);
    for (int i = 0; i < 11; i++) drive(1'b0, 1'b0);
    // Mid-operation reset at 1011, then resume from 0001.
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    // Reset pulses between edges must not disturb counting.
    for (int i = 0; i < 40; i++) drive(1'b0, (i % 3) == 0);
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 29) == 0, $urandom_range(0, 3) == 0);
    end
    for (int i = 0; i < 40; i++) drive(1'b0, 1'b0);
    done = 1'b1;
    #30;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
